// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program counter with next-PC selection and a return-address stack
//
// Computes the next program counter from one of five sources (sequential,
// PC-relative branch, pseudo-direct jump, register jump, return-from-stack)
// and keeps a small circular return-address stack (RAS) for call/return
// prediction.  The PC register loads pc_next on every enabled rising edge.
//
// Parameters
//   W          PC/address width in bits (28..64)
//   RAS_DEPTH  number of return-address-stack entries (1..16)
//   RESET_VEC  PC value loaded on reset (bits [1:0] must be 0)
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   clr          in   asynchronous active-high reset
//   en           in   PC write enable; when low nothing changes
//   pc_sel       in   next-PC source: 0 SEQ, 1 BRANCH, 2 JUMP, 3 JREG,
//                     4 RET, 5..7 behave as SEQ
//   branch_off   in   sign-extended word offset for BRANCH
//   jump_target  in   26-bit instruction index for JUMP
//   reg_target   in   register-sourced target for JREG
//   call         in   push the return address (pc + 4) onto the RAS
//   pc           out  current PC (registered)
//   pc_next      out  combinational next-PC value
//   ras_count    out  number of valid RAS entries, 0..RAS_DEPTH
//   ras_ovf      out  sticky: a push happened while the RAS was full
//   ras_unf      out  sticky: a pop happened while the RAS was empty
//   misalign     out  sticky: a JREG target had nonzero bits [1:0]
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int unsigned  W         = 32,
  parameter int unsigned  RAS_DEPTH = 4,
  parameter logic [W-1:0] RESET_VEC = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [2:0]   pc_sel,
  input  logic [W-1:0] branch_off,
  input  logic [25:0]  jump_target,
  input  logic [W-1:0] reg_target,
  input  logic         call,
  output logic [W-1:0] pc,
  output logic [W-1:0] pc_next,
  output logic [4:0]   ras_count,
  output logic         ras_ovf,
  output logic         ras_unf,
  output logic         misalign
);

  // ---------------------------------------------------------------------------
  // Local constants
  // ---------------------------------------------------------------------------
  localparam logic [2:0] SEL_SEQ    = 3'd0;
  localparam logic [2:0] SEL_BRANCH = 3'd1;
  localparam logic [2:0] SEL_JUMP   = 3'd2;
  localparam logic [2:0] SEL_JREG   = 3'd3;
  localparam logic [2:0] SEL_RET    = 3'd4;

  // Pointer is sized to the storage array exactly; a depth of 1 still gets a
  // one-bit pointer so the array index never collapses to zero width.
  localparam int unsigned      PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned      SLOTS   = 1 << PTR_W;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [4:0]       CNT_MAX = 5'(RAS_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [W-1:0]     pc_q;
  logic [PTR_W-1:0] ptr_q,  ptr_d;     // index of the current top entry
  logic [4:0]       count_q, count_d;
  logic             ovf_q,  ovf_d;
  logic             unf_q,  unf_d;
  logic             mis_q,  mis_d;

  // RAS storage.  Read combinationally because RET must steer pc_next in the
  // same cycle, so this is a register array rather than a block RAM.  Slots
  // beyond RAS_DEPTH (non-power-of-two depths) are never addressed.
  logic [W-1:0]     ras_mem [SLOTS];

  // RAS write port control
  logic             ras_wr_en;
  logic [PTR_W-1:0] ras_wr_idx;

  // ---------------------------------------------------------------------------
  // Address arithmetic (all of it wraps modulo 2^W)
  // ---------------------------------------------------------------------------
  logic [W-1:0]     pc_plus;
  logic [W-1:0]     branch_addr;
  logic [W-1:0]     jump_addr;
  logic [W-1:0]     jreg_addr;
  logic [W-1:0]     ras_top;
  logic             ras_empty;
  logic             is_ret;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;

  assign pc_plus     = pc_q + W'(4);
  assign branch_addr = pc_plus + (branch_off << 2);
  assign jreg_addr   = {reg_target[W-1:2], 2'b00};
  assign ras_top     = ras_mem[ptr_q];
  assign ras_empty   = (count_q == 5'd0);
  assign is_ret      = (pc_sel == SEL_RET);

  // Circular pointer movement: wrap at RAS_DEPTH rather than at 2^PTR_W so
  // a full stack overwrites exactly the oldest entry.
  assign ptr_inc = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec = (ptr_q == '0) ? PTR_MAX : ptr_q - PTR_W'(1);

  // Pseudo-direct jump keeps the region bits above bit 27; at W == 28 there
  // are none left, so the target is the index field alone.
  generate
    if (W > 28) begin : g_jump_region
      assign jump_addr = {pc_plus[W-1:28], jump_target, 2'b00};
    end else begin : g_jump_flat
      assign jump_addr = {jump_target, 2'b00};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-PC selection
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_next = pc_plus;
    case (pc_sel)
      SEL_SEQ:    pc_next = pc_plus;
      SEL_BRANCH: pc_next = branch_addr;
      SEL_JUMP:   pc_next = jump_addr;
      SEL_JREG:   pc_next = jreg_addr;
      SEL_RET:    pc_next = ras_empty ? pc_plus : ras_top;
      default:    pc_next = pc_plus;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RAS and flag next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    ptr_d      = ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    mis_d      = mis_q;
    ras_wr_en  = 1'b0;
    ras_wr_idx = ptr_q;

    if (en) begin
      if (call && is_ret) begin
        // Tail call through a return: the top is consumed and replaced by the
        // new return address in one step.  With nothing to consume it falls
        // back to a plain push and records the underflow.
        if (!ras_empty) begin
          ras_wr_en  = 1'b1;
          ras_wr_idx = ptr_q;
        end else begin
          ras_wr_en  = 1'b1;
          ras_wr_idx = ptr_inc;
          ptr_d      = ptr_inc;
          count_d    = 5'd1;
          unf_d      = 1'b1;
        end
      end else if (call) begin
        ras_wr_en  = 1'b1;
        ras_wr_idx = ptr_inc;
        ptr_d      = ptr_inc;
        if (count_q == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + 5'd1;
        end
      end else if (is_ret) begin
        if (!ras_empty) begin
          ptr_d   = ptr_dec;
          count_d = count_q - 5'd1;
        end else begin
          unf_d = 1'b1;
        end
      end

      if ((pc_sel == SEL_JREG) && (reg_target[1:0] != 2'b00)) begin
        mis_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q <= RESET_VEC;
    end else if (en) begin
      pc_q <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ptr_q   <= '0;
      count_q <= 5'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      mis_q   <= mis_d;
    end
  end

  // Entry storage carries no reset; ras_count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (ras_wr_en && !clr) begin
      ras_mem[ras_wr_idx] <= pc_plus;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pc        = pc_q;
  assign ras_count = count_q;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;
  assign misalign  = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit -- directed self-checking bench for pc_unit (W=32, RAS_DEPTH=4,
// RESET_VEC=0).  Inputs change 1 ns after a rising edge; outputs are sampled
// 1 ns after the next rising edge.
// -----------------------------------------------------------------------------
module tb_pc_unit;

  logic        clk;
  logic        clr;
  logic        en;
  logic [2:0]  pc_sel;
  logic [31:0] branch_off;
  logic [25:0] jump_target;
  logic [31:0] reg_target;
  logic        call;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [4:0]  ras_count;
  logic        ras_ovf;
  logic        ras_unf;
  logic        misalign;

  int n_checks = 0;
  int n_fail   = 0;

  pc_unit #(
    .W        (32),
    .RAS_DEPTH(4),
    .RESET_VEC(32'h0)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .pc_sel     (pc_sel),
    .branch_off (branch_off),
    .jump_target(jump_target),
    .reg_target (reg_target),
    .call       (call),
    .pc         (pc),
    .pc_next    (pc_next),
    .ras_count  (ras_count),
    .ras_ovf    (ras_ovf),
    .ras_unf    (ras_unf),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers (no checking inside)
  task automatic drive(input logic e, input logic [2:0] s,
                       input logic [31:0] rt, input logic c);
    en         = e;
    pc_sel     = s;
    reg_target = rt;
    call       = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    $display("[%0t] en=%0b sel=%0d call=%0b -> pc=%h cnt=%0d ovf=%0b unf=%0b mis=%0b",
             $time, en, pc_sel, call, pc, ras_count, ras_ovf, ras_unf, misalign);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clr = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 1'b0);
    branch_off  = 32'h0;
    jump_target = 26'h0;
    tick();
    n_checks++;
    if (pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0);
    end
    n_checks++;
    if ({ras_count, ras_ovf, ras_unf, misalign} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: got cnt=%0d ovf=%0b unf=%0b mis=%0b expected all 0",
               ras_count, ras_ovf, ras_unf, misalign);
    end
    #3 clr = 1'b0;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_seq();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    drive(1'b1, 3'd0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (pc_next !== exp_pc[i]) begin
        n_fail++; $display("FAIL seq_pc_next%0d: got %h expected %h", i, pc_next, exp_pc[i]);
      end
      tick();
      n_checks++;
      if (pc !== exp_pc[i]) begin
        n_fail++; $display("FAIL seq_pc%0d: got %h expected %h", i, pc, exp_pc[i]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_sel_alias();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h10; exp_pc[1] = 32'h14; exp_pc[2] = 32'h18;
    reg_target  = 32'h0000_8000;
    jump_target = 26'h3FF_FFFF;
    branch_off  = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'(5 + i), 32'h0000_8000, 1'b0);
      tick();
      n_checks++;
      if (pc !== exp_pc[i]) begin
        n_fail++; $display("FAIL sel_alias%0d: got %h expected %h", 5 + i, pc, exp_pc[i]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_branch();
    drive(1'b1, 3'd3, 32'h0000_0100, 1'b0);
    tick();
    n_checks++;
    if (pc !== 32'h100) begin
      n_fail++; $display("FAIL br_setup: got %h expected %h", pc, 32'h100);
    end
    branch_off = 32'hFFFF_FFFE;
    drive(1'b1, 3'd1, 32'h0, 1'b0);
    #1;
    n_checks++;
    if (pc_next !== 32'hFC) begin
      n_fail++; $display("FAIL br_pc_next: got %h expected %h", pc_next, 32'hFC);
    end
    tick();
    n_checks++;
    if (pc !== 32'hFC) begin
      n_fail++; $display("FAIL br_back: got %h expected %h", pc, 32'hFC);
    end
    drive(1'b1, 3'd3, 32'hFFFF_FFFC, 1'b0);
    tick();
    drive(1'b1, 3'd0, 32'h0, 1'b0);
    tick();
    n_checks++;
    if (pc !== 32'h0) begin
      n_fail++; $display("FAIL seq_wrap: got %h expected %h", pc, 32'h0);
    end
    n_checks++;
    if (misalign !== 1'b0) begin
      n_fail++; $display("FAIL aligned_jr_no_flag: got %0b expected 0", misalign);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_jump_hold();
    drive(1'b1, 3'd3, 32'h4000_0010, 1'b0);
    tick();
    jump_target = 26'h000_0020;
    drive(1'b1, 3'd2, 32'h0, 1'b0);
    tick();
    n_checks++;
    if (pc !== 32'h4000_0080) begin
      n_fail++; $display("FAIL jump: got %h expected %h", pc, 32'h4000_0080);
    end
    // Disabled cycle: a call must not push and the PC must hold
    drive(1'b0, 3'd0, 32'h0, 1'b1);
    tick();
    n_checks++;
    if (pc !== 32'h4000_0080) begin
      n_fail++; $display("FAIL en0_hold: got %h expected %h", pc, 32'h4000_0080);
    end
    n_checks++;
    if (ras_count !== 5'd0) begin
      n_fail++; $display("FAIL en0_no_push: got %0d expected 0", ras_count);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ras_overflow();
    logic [31:0] tgt [5];
    logic [4:0]  exp_cnt [5];
    logic [31:0] exp_ret [5];
    tgt[0] = 32'h10; tgt[1] = 32'h20; tgt[2] = 32'h30; tgt[3] = 32'h40; tgt[4] = 32'h1000;
    exp_cnt[0] = 5'd1; exp_cnt[1] = 5'd2; exp_cnt[2] = 5'd3; exp_cnt[3] = 5'd4; exp_cnt[4] = 5'd4;
    exp_ret[0] = 32'h44; exp_ret[1] = 32'h34; exp_ret[2] = 32'h24; exp_ret[3] = 32'h14;
    exp_ret[4] = 32'h18;

    drive(1'b1, 3'd3, 32'h0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd3, tgt[i], 1'b1);
      tick();
      n_checks++;
      if (ras_count !== exp_cnt[i]) begin
        n_fail++; $display("FAIL call_cnt%0d: got %0d expected %0d", i, ras_count, exp_cnt[i]);
      end
      n_checks++;
      if (ras_ovf !== (i == 4)) begin
        n_fail++; $display("FAIL call_ovf%0d: got %0b expected %0b", i, ras_ovf, (i == 4));
      end
    end

    // Disabled RET: nothing pops
    drive(1'b0, 3'd4, 32'h0, 1'b0);
    tick();
    n_checks++;
    if (pc !== 32'h1000 || ras_count !== 5'd4) begin
      n_fail++; $display("FAIL en0_ret_hold: got pc=%h cnt=%0d expected pc=%h cnt=4",
                         pc, ras_count, 32'h1000);
    end

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd4, 32'h0, 1'b0);
      #1;
      n_checks++;
      if (pc_next !== exp_ret[i]) begin
        n_fail++; $display("FAIL ret_pc_next%0d: got %h expected %h", i, pc_next, exp_ret[i]);
      end
      tick();
      n_checks++;
      if (pc !== exp_ret[i]) begin
        n_fail++; $display("FAIL ret_pc%0d: got %h expected %h", i, pc, exp_ret[i]);
      end
      n_checks++;
      if (ras_unf !== (i == 4)) begin
        n_fail++; $display("FAIL ret_unf%0d: got %0b expected %0b", i, ras_unf, (i == 4));
      end
    end
    n_checks++;
    if (ras_count !== 5'd0) begin
      n_fail++; $display("FAIL ret_cnt_end: got %0d expected 0", ras_count);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_call_ret();
    drive(1'b1, 3'd3, 32'h7C, 1'b0);
    tick();
    drive(1'b1, 3'd3, 32'h200, 1'b1);   // pushes 0x80
    tick();
    drive(1'b1, 3'd4, 32'h0, 1'b1);     // return to 0x80, top becomes 0x204
    tick();
    n_checks++;
    if (pc !== 32'h80) begin
      n_fail++; $display("FAIL callret_pc: got %h expected %h", pc, 32'h80);
    end
    n_checks++;
    if (ras_count !== 5'd1) begin
      n_fail++; $display("FAIL callret_cnt: got %0d expected 1", ras_count);
    end
    drive(1'b1, 3'd4, 32'h0, 1'b0);
    tick();
    n_checks++;
    if (pc !== 32'h204 || ras_count !== 5'd0) begin
      n_fail++; $display("FAIL callret_top: got pc=%h cnt=%0d expected pc=%h cnt=0",
                         pc, ras_count, 32'h204);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_misalign_reset();
    drive(1'b1, 3'd3, 32'h1003, 1'b1); // also push something to be discarded
    tick();
    n_checks++;
    if (pc !== 32'h1000) begin
      n_fail++; $display("FAIL jr_mask: got %h expected %h", pc, 32'h1000);
    end
    n_checks++;
    if (misalign !== 1'b1 || ras_count !== 5'd1) begin
      n_fail++; $display("FAIL jr_misalign: got mis=%0b cnt=%0d expected mis=1 cnt=1",
                         misalign, ras_count);
    end
    drive(1'b1, 3'd0, 32'h0, 1'b0);
    #2 clr = 1'b1;
    #1;
    n_checks++;
    if (pc !== 32'h0) begin
      n_fail++; $display("FAIL async_clr_pc: got %h expected %h", pc, 32'h0);
    end
    n_checks++;
    if ({ras_count, ras_ovf, ras_unf, misalign} !== 8'h00) begin
      n_fail++;
      $display("FAIL async_clr_state: got cnt=%0d ovf=%0b unf=%0b mis=%0b expected all 0",
               ras_count, ras_ovf, ras_unf, misalign);
    end
    tick();
    n_checks++;
    if (pc !== 32'h0) begin
      n_fail++; $display("FAIL clr_held_pc: got %h expected %h", pc, 32'h0);
    end
    clr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_call_ret_empty();
    drive(1'b1, 3'd4, 32'h0, 1'b1);
    #1;
    n_checks++;
    if (pc_next !== 32'h4) begin
      n_fail++; $display("FAIL empty_callret_next: got %h expected %h", pc_next, 32'h4);
    end
    tick();
    n_checks++;
    if (ras_count !== 5'd1 || ras_unf !== 1'b1) begin
      n_fail++; $display("FAIL empty_callret: got cnt=%0d unf=%0b expected cnt=1 unf=1",
                         ras_count, ras_unf);
    end
    n_checks++;
    if (ras_ovf !== 1'b0 || misalign !== 1'b0) begin
      n_fail++; $display("FAIL empty_callret_flags: got ovf=%0b mis=%0b expected 0 0",
                         ras_ovf, misalign);
    end
    drive(1'b1, 3'd4, 32'h0, 1'b0);
    tick();
    n_checks++;
    if (pc !== 32'h4 || ras_count !== 5'd0) begin
      n_fail++; $display("FAIL empty_callret_pop: got pc=%h cnt=%0d expected pc=%h cnt=0",
                         pc, ras_count, 32'h4);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_seq();
    test_sel_alias();
    test_branch();
    test_jump_hold();
    test_ras_overflow();
    test_call_ret();
    test_misalign_reset();
    test_call_ret_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
